pe_ctrl: RTL and testbench
==========================

# pe_ctrl

Sequencer for a single weight-stationary MAC processing element (`pe`). It loads a weight vector into the PE register file, streams activations against the resident weights, and asserts `finish` at the end of each dot product. It returns each dot-product result on a valid/ready port. It sits between the array-level scheduler (weight/activation/result streams) and one `pe` instance, whose accumulator is never cleared between dot products; this block recovers per-dot-product results by baseline subtraction.

## Interface
- `PRECISION`, 16, data width of weights, activations, results (must match the attached `pe`)
- `REG_SIZE`, 4, PE register-file entries and PE `addr` width; entry 0 is the accumulator, weights occupy 1..REG_SIZE-1

- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high; the same net also drives the attached `pe` reset
- `start`  in  1  command strobe, sampled only in IDLE
- `cfg_len`  in  REG_SIZE  dot-product length (weights/activations per result)
- `cfg_load`  in  1  1: load `cfg_len` new weights first; 0: reuse resident weights
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  one-cycle pulse when a `start` is rejected
- `w_valid` / `w_ready` / `w_data`  in / out / in  1 / 1 / PRECISION  weight stream
- `a_valid` / `a_ready` / `a_data`  in / out / in  1 / 1 / PRECISION  activation stream
- `res_valid` / `res_ready` / `res_data`  out / in / out  1 / 1 / PRECISION  result stream
- `pe_act`, `pe_wgt`  out  PRECISION  to PE `act`, `wgt`
- `pe_store`, `pe_reuse`, `pe_finish`  out  1  to PE `store`, `reuse`, `finish`
- `pe_addr`  out  REG_SIZE  to PE `addr`
- `pe_out`  in  PRECISION  from PE `out`

## Operation
- The PE adds `act * (reuse ? reg[addr] : wgt)` into its accumulator every cycle. Therefore `pe_act` = 0 in every cycle without an activation handshake. This includes IDLE, LOAD, stalls, FIN, CAP and OUT.
- Default PE drive: `pe_act`=0, `pe_wgt`=0, `pe_store`=0, `pe_reuse`=0, `pe_finish`=0, `pe_addr`=0.
- Effective length: `len` = min(`cfg_len`, REG_SIZE-1), latched at accept.
- Register `wcnt` holds the number of resident weights. It resets to 0 and is set to `len` when a LOAD completes.
- States:
  - IDLE: `start` is rejected (`err`=1 next cycle, stay IDLE) when `cfg_len`=0, or when `cfg_load`=0 and `len` > `wcnt`. Otherwise the command is accepted: `cnt`<=1, then go to LOAD if `cfg_load`=1, else MAC.
  - LOAD: `w_ready`=1. On `w_valid`: `pe_store`=1, `pe_addr`=`cnt`, `pe_wgt`=`w_data` (combinational pass-through), `cnt`++. After the handshake at `cnt`=`len`: `wcnt`<=`len`, `cnt`<=1, go to MAC.
  - MAC: `a_ready`=1. On `a_valid`: `pe_act`=`a_data`, `pe_reuse`=1, `pe_addr`=`cnt`, `cnt`++. After the handshake at `cnt`=`len`, go to FIN.
  - FIN (1 cycle): `pe_finish`=1. Go to CAP.
  - CAP (1 cycle): `res_data` <= `pe_out` − `base` (mod 2^PRECISION); `base` <= `pe_out`. Go to OUT.
  - OUT: `res_valid`=1. On `res_ready`, go to IDLE.
- `base` resets to 0. Because the PE accumulator also resets to 0 and wraps mod 2^PRECISION, the subtraction is exact, including across wrap.
- Products and sums are truncated to PRECISION bits, matching the PE.
- `w_ready` is 0 outside LOAD and `a_ready` is 0 outside MAC. Stream data presented outside those states is not consumed.
- `start` received while `busy` is ignored; it is neither queued nor flagged as an error.

## Timing
- Reset values: state IDLE; `busy`, `err`, `w_ready`, `a_ready`, `res_valid` = 0; `res_data` = 0; `base` = 0; `wcnt` = 0; all `pe_*` outputs = 0.
- A reset in any state returns to IDLE on the next edge. Any in-flight result is dropped, and `wcnt`=0 because the PE register file is cleared by the same reset.
- `start` accepted at edge t: `busy`=1 from cycle t+1. The first LOAD/MAC handshake can occur in cycle t+1.
- Last activation handshake in cycle n: FIN in n+1, CAP in n+2, `res_valid`=1 from n+3. The fastest path returns to IDLE at end of n+3.
- Minimum command period = `len` (+`len` if loading) + 4 cycles.
- `res_data` is stable and `res_valid` is held while `res_ready`=0. Stream bubbles add cycles only; they never add to the accumulator.
- `err` is high for exactly one cycle per rejected `start`.

## Test plan
- Reset, then `start` with `cfg_load`=1, `cfg_len`=3; weights 2,3,5; activations 1,1,1 back-to-back → `res_data`=10, `res_valid` rises 3 cycles after the last `a` handshake.
- Follow-up `start` with `cfg_load`=0, `cfg_len`=3; activations 2,0,1 → `res_data`=9 (baseline subtraction correct). A third run with activations 1,0,0 → 2.
- Random `w_valid`/`a_valid` gaps and `res_ready` held low for 5 cycles → results identical to the no-gap case; `res_valid`/`res_data` held stable; `pe_act`=0 in every gap cycle.
- After reset, `start` with `cfg_load`=0 → one-cycle `err`, `busy` stays 0. `start` with `cfg_len`=0 → `err`. `cfg_len`=7 with REG_SIZE=4 → exactly 3 weights and 3 activations consumed.
- PRECISION=16: weight 0xFFFF, activation 2, length 1 → 0xFFFE. Then weight 1, activation 3 → 0x0003 despite accumulator wrap.
- Assert `rst` in the middle of MAC → IDLE next cycle, no `res_valid`. A subsequent full load+MAC run (weights 4,4; acts 1,2) → 12.

Source files
------------

// File: rtl/pe_ctrl_if.sv
// Stream and PE-drive bundle between pe_ctrl, the array scheduler and one pe.
// Latency: wiring only.
// Backpressure: each stream carries its own valid/ready pair; the PE side has none.
interface pe_ctrl_if #(
  parameter int PRECISION = 16,
  parameter int REG_SIZE  = 4
);
  logic                 w_valid;
  logic                 w_ready;
  logic [PRECISION-1:0] w_data;
  logic                 a_valid;
  logic                 a_ready;
  logic [PRECISION-1:0] a_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [PRECISION-1:0] res_data;
  logic [PRECISION-1:0] pe_act;
  logic [PRECISION-1:0] pe_wgt;
  logic                 pe_store;
  logic                 pe_reuse;
  logic                 pe_finish;
  logic [REG_SIZE-1:0]  pe_addr;
  logic [PRECISION-1:0] pe_out;

  // Controller side.
  modport master (
    input  w_valid, w_data, a_valid, a_data, res_ready, pe_out,
    output w_ready, a_ready, res_valid, res_data,
           pe_act, pe_wgt, pe_store, pe_reuse, pe_finish, pe_addr
  );

  // Scheduler and PE side.
  modport slave (
    output w_valid, w_data, a_valid, a_data, res_ready, pe_out,
    input  w_ready, a_ready, res_valid, res_data,
           pe_act, pe_wgt, pe_store, pe_reuse, pe_finish, pe_addr
  );
endinterface

// File: rtl/pe_ctrl.sv
// Sequencer for one weight-stationary MAC PE: loads weights, streams activations, returns dot products.
// Latency: last activation handshake in cycle n -> res_valid from n+3; command period len(+len if loading)+4.
// Backpressure: w/a streams stall the sequence without touching the accumulator; res_valid/res_data hold until res_ready.
module pe_ctrl #(
  parameter int PRECISION = 16,
  parameter int REG_SIZE  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [REG_SIZE-1:0] cfg_len,
  input  logic                cfg_load,
  output logic                busy,
  output logic                err,
  pe_ctrl_if.master           bus
);

  localparam int                  MAX_LEN_I = REG_SIZE - 1;
  localparam logic [REG_SIZE-1:0] MAX_LEN   = MAX_LEN_I[REG_SIZE-1:0];
  localparam logic [REG_SIZE-1:0] ONE       = {{(REG_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_FIN,
    S_CAP,
    S_OUT
  } state_t;

  state_t               state;
  logic [REG_SIZE-1:0]  cnt;
  logic [REG_SIZE-1:0]  len;
  logic [REG_SIZE-1:0]  wcnt;
  logic [PRECISION-1:0] base;
  logic [REG_SIZE-1:0]  len_in;
  logic                 reject;

  // Clamp the requested length to the number of weight slots (entry 0 is the accumulator).
  always_comb begin
    len_in = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    reject = (cfg_len == '0) || (!cfg_load && (len_in > wcnt));
  end

  // Command sequencer; also owns the result register, the baseline and the resident-weight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      len           <= '0;
      wcnt          <= '0;
      base          <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              len   <= len_in;
              cnt   <= ONE;
              busy  <= 1'b1;
              state <= cfg_load ? S_LOAD : S_MAC;
            end
          end
        end
        S_LOAD: begin
          if (bus.w_valid) begin
            if (cnt == len) begin
              wcnt  <= len;
              cnt   <= ONE;
              state <= S_MAC;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_MAC: begin
          if (bus.a_valid) begin
            if (cnt == len) begin
              state <= S_FIN;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_FIN: begin
          state <= S_CAP;
        end
        S_CAP: begin
          // The PE accumulator is never cleared, so the result is the delta since the last capture.
          bus.res_data  <= bus.pe_out - base;
          base          <= bus.pe_out;
          bus.res_valid <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stream readiness and PE drive; act stays zero unless an activation is actually handed over.
  always_comb begin
    bus.w_ready   = (state == S_LOAD);
    bus.a_ready   = (state == S_MAC);
    bus.pe_finish = (state == S_FIN);
    bus.pe_act    = '0;
    bus.pe_wgt    = '0;
    bus.pe_store  = 1'b0;
    bus.pe_reuse  = 1'b0;
    bus.pe_addr   = '0;
    if ((state == S_LOAD) && bus.w_valid) begin
      bus.pe_store = 1'b1;
      bus.pe_addr  = cnt;
      bus.pe_wgt   = bus.w_data;
    end
    if ((state == S_MAC) && bus.a_valid) begin
      bus.pe_act   = bus.a_data;
      bus.pe_reuse = 1'b1;
      bus.pe_addr  = cnt;
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with a behavioural weight-stationary PE attached.
// Latency: checks res_valid three cycles after the last activation handshake.
// Backpressure: exercises stream gaps and a held result port.
module tb_pe_ctrl;
  localparam int PRECISION = 16;
  localparam int REG_SIZE  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [REG_SIZE-1:0]  cfg_len;
  logic                 cfg_load;
  logic                 busy;
  logic                 err;

  int n_cmp = 0;
  int n_err = 0;
  int last_wi;
  int last_ai;
  logic [PRECISION-1:0] wv [8];
  logic [PRECISION-1:0] av [8];
  logic [PRECISION-1:0] pe_rf [16];

  pe_ctrl_if #(.PRECISION(PRECISION), .REG_SIZE(REG_SIZE)) bus ();

  pe_ctrl #(.PRECISION(PRECISION), .REG_SIZE(REG_SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_load (cfg_load),
    .busy     (busy),
    .err      (err),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural PE: accumulate act * (reuse ? reg[addr] : wgt) into entry 0 every cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pe_rf[i] <= '0;
    end else begin
      if (bus.pe_store) pe_rf[bus.pe_addr] <= bus.pe_wgt;
      pe_rf[0] <= pe_rf[0] + bus.pe_act * (bus.pe_reuse ? pe_rf[bus.pe_addr] : bus.pe_wgt);
    end
  end
  assign bus.pe_out = pe_rf[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setw(input logic [15:0] w0, w1, w2, w3, w4);
    wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3; wv[4] = w4;
  endtask

  task automatic seta(input logic [15:0] a0, a1, a2, a3, a4);
    av[0] = a0; av[1] = a1; av[2] = a2; av[3] = a3; av[4] = a4;
  endtask

  // Issue one command and drive both streams until the result is taken.
  task automatic run(input string tag, input logic ld, input logic [3:0] len, input int nw, input int na,
                     input bit gaps, input int hold, input logic [15:0] exp);
    int wi = 0;
    int ai = 0;
    int cyc = 0;
    int last_a = 0;
    int rv_cnt = 0;
    bit seen = 0;
    bit done = 0;
    bit whs;
    bit ahs;
    logic [15:0] held = '0;
    start = 1'b1; cfg_len = len; cfg_load = ld;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 300) begin
      bus.w_valid   = (wi < nw) && !(gaps && $urandom_range(0, 2) == 0);
      bus.w_data    = bus.w_valid ? wv[wi] : 16'hBEEF;
      bus.a_valid   = (ai < na) && !(gaps && $urandom_range(0, 2) == 0);
      bus.a_data    = bus.a_valid ? av[ai] : 16'h00AA;
      bus.res_ready = (rv_cnt >= hold);
      @(negedge clk);
      whs = bus.w_valid && bus.w_ready;
      ahs = bus.a_valid && bus.a_ready;
      if (!ahs) check({tag, "_act_zero"}, bus.pe_act, 0);
      if (ahs) last_a = cyc;
      if (bus.res_valid) begin
        if (!seen) begin
          seen = 1;
          held = bus.res_data;
          check({tag, "_latency"}, cyc - last_a, 3);
        end else begin
          check({tag, "_hold_data"}, bus.res_data, held);
        end
        if (bus.res_ready) done = 1;
        rv_cnt++;
      end else if (seen) begin
        check({tag, "_hold_valid"}, bus.res_valid, 1);
      end
      @(posedge clk); #1;
      if (whs) wi++;
      if (ahs) ai++;
      cyc++;
    end
    bus.w_valid = 1'b0; bus.a_valid = 1'b0; bus.res_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check(tag, held, exp);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    @(posedge clk); #1;
    last_wi = wi;
    last_ai = ai;
  endtask

  // Issue a command that must be refused: one-cycle err, never busy.
  task automatic try_reject(input string tag, input logic ld, input logic [3:0] len);
    start = 1'b1; cfg_len = len; cfg_load = ld;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_clr"}, err, 0);
    check({tag, "_busy_clr"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_load = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = 16'h1234;
    bus.a_valid = 1'b1; bus.a_data = 16'h5678;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_pe_act", bus.pe_act, 0);
    check("rst_pe_wgt", bus.pe_wgt, 0);
    check("rst_pe_ctl", {bus.pe_store, bus.pe_reuse, bus.pe_finish}, 0);
    check("rst_pe_addr", bus.pe_addr, 0);
    @(posedge clk); #1;
    bus.w_valid = 1'b0; bus.a_valid = 1'b0;

    setw(16'd2, 16'd3, 16'd5, 16'd0, 16'd0);
    seta(16'd1, 16'd1, 16'd1, 16'd0, 16'd0);
    run("load_run", 1'b1, 4'd3, 3, 3, 0, 0, 16'd10);
    seta(16'd2, 16'd0, 16'd1, 16'd0, 16'd0);
    run("reuse_run", 1'b0, 4'd3, 0, 3, 0, 0, 16'd9);
    seta(16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
    run("reuse_run2", 1'b0, 4'd3, 0, 3, 0, 0, 16'd2);
    seta(16'd1, 16'd1, 16'd1, 16'd0, 16'd0);
    run("gap_run", 1'b1, 4'd3, 3, 3, 1, 5, 16'd10);

    pulse_rst();
    try_reject("rej_noweights", 1'b0, 4'd1);
    try_reject("rej_zero_len", 1'b1, 4'd0);

    setw(16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    seta(16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    run("clamp_run", 1'b1, 4'd7, 5, 5, 0, 0, 16'd3);
    check("clamp_w_count", last_wi, 3);
    check("clamp_a_count", last_ai, 3);

    setw(16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0);
    seta(16'd2, 16'd0, 16'd0, 16'd0, 16'd0);
    run("wrap_run", 1'b1, 4'd1, 1, 1, 0, 0, 16'hFFFE);
    setw(16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
    seta(16'd3, 16'd0, 16'd0, 16'd0, 16'd0);
    run("wrap_run2", 1'b1, 4'd1, 1, 1, 0, 0, 16'h0003);

    // Reset in the middle of MAC: load two weights, take one activation, then reset.
    start = 1'b1; cfg_len = 4'd2; cfg_load = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = 16'd9;
    repeat (2) @(posedge clk);
    #1 bus.w_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_data = 16'd7;
    @(negedge clk);
    check("mid_in_mac", bus.a_ready, 1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    pulse_rst();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_a_ready", bus.a_ready, 0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_res", bus.res_valid, 0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    try_reject("mid_rst_wcnt", 1'b0, 4'd1);
    setw(16'd4, 16'd4, 16'd0, 16'd0, 16'd0);
    seta(16'd1, 16'd2, 16'd0, 16'd0, 16'd0);
    run("after_rst_run", 1'b1, 4'd2, 2, 2, 0, 0, 16'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
